// File: rtl/rx_fifo_scheduler_pkg.sv
// Shared definitions for the RX FIFO scheduler: mode codes, FSM states and
// channel identifiers used by the top and the word serializer.
package rx_fifo_scheduler_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    MODE_09   = 2'b00,
    MODE_24   = 2'b01,
    MODE_RR   = 2'b10,
    MODE_HALT = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_PULL  = 3'd2,
    ST_LATCH = 3'd3,
    ST_SEND  = 3'd4
  } state_e;

  localparam logic CH_09 = 1'b0;
  localparam logic CH_24 = 1'b1;

endpackage

// File: rtl/rx_fifo_scheduler_word_serializer.sv
// 32->8 shift register: emits a loaded word MSB byte first over valid/ready,
// flags the final byte and pulses o_done when that byte is accepted.
module rx_fifo_scheduler_word_serializer
  import rx_fifo_scheduler_pkg::*;
(
  input  logic              i_sys_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_chan,
  input  logic              i_ready,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_chan,
  output logic              o_last,
  output logic              o_done
);

  logic [WORD_W-1:0] r_shift;
  logic [1:0]        r_idx;
  logic              r_valid;
  logic              r_chan;
  logic              w_xfer;

  assign w_xfer = r_valid & i_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_shift <= '0;
      r_idx   <= 2'd0;
      r_valid <= 1'b0;
      r_chan  <= CH_09;
    end else if (i_load) begin
      r_shift <= i_word;
      r_idx   <= 2'd0;
      r_valid <= 1'b1;
      r_chan  <= i_chan;
    end else if (w_xfer) begin
      r_shift <= {r_shift[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      r_idx   <= r_idx + 2'd1;
      if (r_idx == 2'd3) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_shift[WORD_W-1 -: BYTE_W];
  assign o_valid = r_valid;
  assign o_chan  = r_chan;
  assign o_last  = r_valid & (r_idx == 2'd3);
  assign o_done  = w_xfer & (r_idx == 2'd3);

endmodule

// File: rtl/rx_fifo_scheduler.sv
// Arbitrates the 0.9 GHz and 2.4 GHz RX FIFOs onto one byte stream for smi_ctrl,
// one 32-bit word per grant, and counts FIFO-full cycles per channel.
module rx_fifo_scheduler
  import rx_fifo_scheduler_pkg::*;
#(
  parameter int BURST_WORDS = 4,
  parameter int CNT_W       = 16
) (
  input  logic              i_sys_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [1:0]        i_mode,
  input  logic              i_cnt_clear,
  input  logic              i_fifo_09_empty,
  input  logic              i_fifo_09_full,
  input  logic [31:0]       i_fifo_09_data,
  output logic              o_fifo_09_pull,
  input  logic              i_fifo_24_empty,
  input  logic              i_fifo_24_full,
  input  logic [31:0]       i_fifo_24_data,
  output logic              o_fifo_24_pull,
  output logic [7:0]        o_byte_data,
  output logic              o_byte_valid,
  input  logic              i_byte_ready,
  output logic              o_byte_chan,
  output logic              o_byte_last,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_overrun_09,
  output logic [CNT_W-1:0]  o_overrun_24
);

  localparam int BW = $clog2(BURST_WORDS + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(BURST_WORDS);

  state_e            r_state;
  state_e            w_next;
  logic              r_grant;
  logic [BW-1:0]     r_burst;
  logic [CNT_W-1:0]  r_ovr_09;
  logic [CNT_W-1:0]  r_ovr_24;

  mode_e             w_mode;
  logic              w_req_09;
  logic              w_req_24;
  logic              w_any_req;
  logic              w_req_last;
  logic              w_req_other;
  logic              w_pick;
  logic [BW-1:0]     w_pick_burst;
  logic              w_pick_ok;
  logic              w_load;
  logic              w_done;
  logic [WORD_W-1:0] w_word;

  assign w_mode    = mode_e'(i_mode);
  assign w_req_09  = i_enable & ((w_mode == MODE_09) | (w_mode == MODE_RR)) & ~i_fifo_09_empty;
  assign w_req_24  = i_enable & ((w_mode == MODE_24) | (w_mode == MODE_RR)) & ~i_fifo_24_empty;
  assign w_any_req = w_req_09 | w_req_24;

  assign w_req_last  = (r_grant == CH_09) ? w_req_09 : w_req_24;
  assign w_req_other = (r_grant == CH_09) ? w_req_24 : w_req_09;

  // A zero burst means no word has been granted in round-robin since reset or
  // a fixed-mode grant, so the grant hands over to the other channel first.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    w_pick       = r_grant;
    w_pick_burst = r_burst;
    w_pick_ok    = 1'b0;
    case (w_mode)
      MODE_09: begin
        w_pick       = CH_09;
        w_pick_burst = '0;
        w_pick_ok    = w_req_09;
      end
      MODE_24: begin
        w_pick       = CH_24;
        w_pick_burst = '0;
        w_pick_ok    = w_req_24;
      end
      MODE_RR: begin
        if (w_req_last && (r_burst != '0) && (r_burst < BURST_MAX)) begin
          w_pick_ok = 1'b1;
        end else if (w_req_other) begin
          w_pick       = ~r_grant;
          w_pick_burst = '0;
          w_pick_ok    = 1'b1;
        end else begin
          w_pick_burst = '0;
          w_pick_ok    = w_req_last;
        end
      end
      default: w_pick_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_next = ST_ARB;
      ST_ARB:   w_next = w_pick_ok ? ST_PULL : ST_IDLE;
      ST_PULL:  w_next = ST_LATCH;
      ST_LATCH: w_next = ST_SEND;
      ST_SEND:  if (w_done) w_next = w_any_req ? ST_ARB : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_grant <= CH_24;
      r_burst <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_ARB && w_pick_ok) begin
        r_grant <= w_pick;
        r_burst <= w_pick_burst;
      end else if (r_state == ST_LATCH) begin
        r_burst <= r_burst + BW'(1);
      end
    end
  end

  // Clear wins over increment; counts saturate at all-ones.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset || i_cnt_clear) begin
      r_ovr_09 <= '0;
      r_ovr_24 <= '0;
    end else begin
      if (i_fifo_09_full && !(&r_ovr_09)) r_ovr_09 <= r_ovr_09 + CNT_W'(1);
      if (i_fifo_24_full && !(&r_ovr_24)) r_ovr_24 <= r_ovr_24 + CNT_W'(1);
    end
  end

  assign o_fifo_09_pull = (r_state == ST_PULL) & (r_grant == CH_09) & ~i_reset;
  assign o_fifo_24_pull = (r_state == ST_PULL) & (r_grant == CH_24) & ~i_reset;

  assign w_load = (r_state == ST_LATCH);
  assign w_word = (r_grant == CH_24) ? i_fifo_24_data : i_fifo_09_data;

  rx_fifo_scheduler_word_serializer u_ser (
    .i_sys_clk (i_sys_clk),
    .i_reset   (i_reset),
    .i_load    (w_load),
    .i_word    (w_word),
    .i_chan    (r_grant),
    .i_ready   (i_byte_ready),
    .o_data    (o_byte_data),
    .o_valid   (o_byte_valid),
    .o_chan    (o_byte_chan),
    .o_last    (o_byte_last),
    .o_done    (w_done)
  );

  assign o_busy       = (r_state != ST_IDLE);
  assign o_overrun_09 = r_ovr_09;
  assign o_overrun_24 = r_ovr_24;

endmodule

// File: tb/tb_rx_fifo_scheduler.sv
// Scoreboard bench for rx_fifo_scheduler: FIFO models feed the DUT, expected
// bytes are queued at stimulus time and a negedge monitor compares transfers.
module tb_rx_fifo_scheduler;

  localparam int BURST_WORDS = 4;
  localparam int CNT_W       = 16;

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_enable;
  logic [1:0]        i_mode;
  logic              i_cnt_clear;
  logic              fifo_09_empty, fifo_09_full;
  logic [31:0]       fifo_09_data;
  logic              o_fifo_09_pull;
  logic              fifo_24_empty, fifo_24_full;
  logic [31:0]       fifo_24_data;
  logic              o_fifo_24_pull;
  logic [7:0]        o_byte_data;
  logic              o_byte_valid;
  logic              i_byte_ready;
  logic              o_byte_chan;
  logic              o_byte_last;
  logic              o_busy;
  logic [CNT_W-1:0]  o_overrun_09;
  logic [CNT_W-1:0]  o_overrun_24;

  always #5 clk = ~clk;

  rx_fifo_scheduler #(.BURST_WORDS(BURST_WORDS), .CNT_W(CNT_W)) dut (
    .i_sys_clk       (clk),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_mode          (i_mode),
    .i_cnt_clear     (i_cnt_clear),
    .i_fifo_09_empty (fifo_09_empty),
    .i_fifo_09_full  (fifo_09_full),
    .i_fifo_09_data  (fifo_09_data),
    .o_fifo_09_pull  (o_fifo_09_pull),
    .i_fifo_24_empty (fifo_24_empty),
    .i_fifo_24_full  (fifo_24_full),
    .i_fifo_24_data  (fifo_24_data),
    .o_fifo_24_pull  (o_fifo_24_pull),
    .o_byte_data     (o_byte_data),
    .o_byte_valid    (o_byte_valid),
    .i_byte_ready    (i_byte_ready),
    .o_byte_chan     (o_byte_chan),
    .o_byte_last     (o_byte_last),
    .o_busy          (o_busy),
    .o_overrun_09    (o_overrun_09),
    .o_overrun_24    (o_overrun_24)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       chan;
    logic       last;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat_cyc = -1;
  int          xfers = 0;
  int          pulls_09 = 0;
  int          pulls_24 = 0;
  exp_t        sb[$];
  logic [31:0] q09[$];
  logic [31:0] q24[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_word(input logic [31:0] w, input logic ch);
    for (int b = 3; b >= 0; b--) begin
      exp_t e;
      e.data = w[b*8 +: 8];
      e.chan = ch;
      e.last = (b == 0);
      sb.push_back(e);
    end
  endtask

  // FIFO models: a pull seen in a cycle presents data for the next edge.
  initial begin
    fifo_09_empty = 1'b1;
    fifo_24_empty = 1'b1;
    fifo_09_data  = '0;
    fifo_24_data  = '0;
  end

  always @(negedge clk) begin
    if (o_fifo_09_pull) begin
      check("pull09_when_nonempty", fifo_09_empty, 0);
      check("pull09_while_byte_valid", o_byte_valid, 0);
      if (q09.size() != 0) fifo_09_data = q09.pop_front();
      pulls_09++;
    end
    if (o_fifo_24_pull) begin
      check("pull24_when_nonempty", fifo_24_empty, 0);
      check("pull24_while_byte_valid", o_byte_valid, 0);
      if (q24.size() != 0) fifo_24_data = q24.pop_front();
      pulls_24++;
    end
    fifo_09_empty = (q09.size() == 0);
    fifo_24_empty = (q24.size() == 0);
  end

  // Byte monitor: compares each accepted byte against the scoreboard.
  logic       prev_stall = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = '0;

  always @(negedge clk) begin
    if (i_reset) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (o_byte_valid && !prev_valid && lat_cyc >= 0) begin
        check("first_byte_latency", cyc - lat_cyc, 4);
        lat_cyc = -1;
      end
      if (prev_stall) begin
        check("stall_valid_held", o_byte_valid, 1);
        check("stall_data_stable", o_byte_data, prev_data);
      end
      if (o_byte_valid && i_byte_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", o_byte_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("byte_data", o_byte_data, e.data);
          check("byte_chan", o_byte_chan, e.chan);
          check("byte_last", o_byte_last, e.last);
        end
        xfers++;
      end
      prev_stall = o_byte_valid && !i_byte_ready;
      prev_data  = o_byte_data;
      prev_valid = o_byte_valid;
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || o_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_complete"}, (sb.size() == 0) && !o_busy, 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int chseq[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};

  initial begin
    int base_x, base_p, n, i09, i24;
    i_reset      = 1'b1;
    i_enable     = 1'b0;
    i_mode       = 2'b11;
    i_cnt_clear  = 1'b0;
    fifo_09_full = 1'b0;
    fifo_24_full = 1'b0;
    i_byte_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", o_byte_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_pull09", o_fifo_09_pull, 0);
    check("rst_pull24", o_fifo_24_pull, 0);
    check("rst_last", o_byte_last, 0);
    check("rst_chan", o_byte_chan, 0);
    check("rst_data", o_byte_data, 0);
    check("rst_ovr09", o_overrun_09, 0);
    check("rst_ovr24", o_overrun_24, 0);
    step();
    i_reset = 1'b0;
    i_enable = 1'b1;
    i_byte_ready = 1'b1;

    // Round robin from reset: both FIFOs preloaded with 6 words while halted
    for (int i = 0; i < 6; i++) begin
      q09.push_back(32'h90A0B000 + i);
      q24.push_back(32'h2400C000 + i);
    end
    i09 = 0;
    i24 = 0;
    for (int k = 0; k < 12; k++) begin
      if (chseq[k] == 0) begin
        expect_word(32'h90A0B000 + i09, 1'b0);
        i09++;
      end else begin
        expect_word(32'h2400C000 + i24, 1'b1);
        i24++;
      end
    end
    step();
    step();
    i_mode = 2'b10;
    wait_done("rr_burst", 400);
    check("rr_pulls09", pulls_09, 6);
    check("rr_pulls24", pulls_24, 6);

    // 09-only single word with latency check
    i_mode = 2'b00;
    step();
    q09.push_back(32'hA1B2C3D4);
    expect_word(32'hA1B2C3D4, 1'b0);
    lat_cyc = cyc;
    wait_done("mode09_word", 40);
    check("mode09_pulls", pulls_09, 7);
    check("latency_seen", lat_cyc, -1);

    // 24-only single word
    i_mode = 2'b01;
    step();
    q24.push_back(32'h55667788);
    expect_word(32'h55667788, 1'b1);
    wait_done("mode24_word", 40);
    check("mode24_pulls", pulls_24, 7);

    // Ready toggling every cycle across two back-to-back words
    i_mode = 2'b00;
    step();
    q09.push_back(32'h11223344);
    q09.push_back(32'h99AABBCC);
    expect_word(32'h11223344, 1'b0);
    expect_word(32'h99AABBCC, 1'b0);
    n = 0;
    while ((sb.size() != 0 || o_busy) && n < 200) begin
      step();
      i_byte_ready = ~i_byte_ready;
      n++;
    end
    check("toggle_complete", (sb.size() == 0) && !o_busy, 1);
    check("toggle_pulls", pulls_09, 9);
    i_byte_ready = 1'b1;

    // Halt requested mid-word: current word completes, no further pulls
    step();
    base_x = xfers;
    base_p = pulls_09;
    q09.push_back(32'hCAFEF00D);
    q09.push_back(32'hDEADBEEF);
    expect_word(32'hCAFEF00D, 1'b0);
    n = 0;
    while (xfers < base_x + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached_byte2", xfers >= base_x + 2, 1);
    step();
    i_mode = 2'b11;
    wait_done("halt_word", 40);
    repeat (10) step();
    check("halt_idle", o_busy, 0);
    check("halt_pulls", pulls_09, base_p + 1);
    check("halt_left_in_fifo", q09.size(), 1);
    q09.delete();
    step();

    // Overrun counters: saturation, independent channels, clear priority
    fifo_09_full = 1'b1;
    repeat (70000) @(posedge clk);
    #1 fifo_09_full = 1'b0;
    @(negedge clk);
    check("ovr09_saturated", o_overrun_09, 16'hFFFF);
    check("ovr24_untouched", o_overrun_24, 0);
    step();
    fifo_24_full = 1'b1;
    repeat (5) @(posedge clk);
    #1 fifo_24_full = 1'b0;
    @(negedge clk);
    check("ovr24_five", o_overrun_24, 5);
    check("ovr09_still_sat", o_overrun_09, 16'hFFFF);
    step();
    i_cnt_clear  = 1'b1;
    fifo_09_full = 1'b1;
    step();
    i_cnt_clear  = 1'b0;
    fifo_09_full = 1'b0;
    @(negedge clk);
    check("clear_beats_full09", o_overrun_09, 0);
    check("clear_ovr24", o_overrun_24, 0);
    step();
    fifo_09_full = 1'b1;
    repeat (3) @(posedge clk);
    #1 fifo_09_full = 1'b0;
    @(negedge clk);
    check("ovr09_count_after_clear", o_overrun_09, 3);

    // Reset while a word is being sent
    step();
    i_mode       = 2'b00;
    i_byte_ready = 1'b0;
    fifo_24_full = 1'b1;
    q09.push_back(32'h0BADF00D);
    expect_word(32'h0BADF00D, 1'b0);
    n = 0;
    while (!o_byte_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_reached", o_byte_valid, 1);
    step();
    i_reset      = 1'b1;
    fifo_24_full = 1'b0;
    step();
    i_reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_valid", o_byte_valid, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_pull09", o_fifo_09_pull, 0);
    check("midrst_pull24", o_fifo_24_pull, 0);
    check("midrst_ovr09", o_overrun_09, 0);
    check("midrst_ovr24", o_overrun_24, 0);
    i_byte_ready = 1'b1;
    repeat (10) step();
    check("midrst_stays_idle", o_busy, 0);
    check("midrst_no_bytes", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
